song_reader: RTL and testbench

Note sequencer feeding the note player: walks a song stored in a synchronous note ROM and issues one note at a time through a `new_note` / `note_done` handshake. It sits between the music-player top level (play/song select) and the note player. It holds each note/duration stable until the player reports completion, then advances. A song ends on a zero-duration entry or after the last ROM slot, signalled with `song_done`.

---
 rtl/song_reader.sv | 115 +++++++++++
 tb/tb_song_reader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/song_reader.sv
// song_reader: note sequencer between the music-player top level and the note player.
// Walks one song in a synchronous note ROM and hands the player one note at a time.
// It waits for the player's completion pulse before moving on. A song ends on a
// zero-duration entry or after the last ROM slot.
module song_reader #(
  parameter int ADDR_W = 5,
  parameter int SONG_W = 2,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     play,
  input  logic [SONG_W-1:0]        song,
  input  logic                     note_done,
  output logic [SONG_W+ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]  rom_data,
  output logic                     new_note,
  output logic [NOTE_W-1:0]        note,
  output logic [DUR_W-1:0]         duration,
  output logic                     song_done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    ISSUE,
    WAIT_DONE,
    END
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [SONG_W-1:0] song_q;
  logic [DUR_W-1:0]  rom_dur;
  logic [NOTE_W-1:0] rom_note;

  // The ROM address is built directly from the song and note registers, so it is registered.
  assign rom_addr = {song_q, addr_q};
  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];

  // Sequencer FSM. Pause takes priority everywhere except END. The pulse outputs are
  // set on the transition into ISSUE/END, so each one is high for exactly that cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      song_q    <= '0;
      note      <= '0;
      duration  <= '0;
      new_note  <= 1'b0;
      song_done <= 1'b0;
    end else begin
      new_note  <= 1'b0;
      song_done <= 1'b0;
      case (state)
        IDLE: begin
          if (play) begin
            if (song != song_q) begin
              addr_q <= '0;
            end
            song_q <= song;
            state  <= FETCH;
          end
        end
        FETCH: begin
          state <= play ? LATCH : IDLE;
        end
        LATCH: begin
          if (!play) begin
            state <= IDLE;
          end else begin
            note     <= rom_note;
            duration <= rom_dur;
            if (rom_dur == '0) begin
              song_done <= 1'b1;
              state     <= END;
            end else begin
              new_note <= 1'b1;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state <= play ? WAIT_DONE : IDLE;
        end
        WAIT_DONE: begin
          if (!play) begin
            state <= IDLE;
          end else if (note_done) begin
            if (addr_q == LAST_ADDR) begin
              song_done <= 1'b1;
              state     <= END;
            end else begin
              addr_q <= addr_q + 1'b1;
              state  <= FETCH;
            end
          end
        end
        END: begin
          addr_q <= '0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: table-driven cycle vectors for a short song.
// Hand-written sequences cover the multi-cycle corners: full song, restart,
// pause, song change, stray note_done, and reset in the middle of a note.
module tb_song_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        play = 1'b0;
  logic [1:0]  song = 2'd0;
  logic        note_done = 1'b0;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data = 12'd0;
  logic        new_note;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        song_done;

  int checks = 0;
  int failures = 0;
  int nn_count = 0;
  int sd_count = 0;

  logic [11:0] rom [0:127];

  song_reader dut (
    .clk       (clk),
    .reset     (reset),
    .play      (play),
    .song      (song),
    .note_done (note_done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .new_note  (new_note),
    .note      (note),
    .duration  (duration),
    .song_done (song_done)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Synchronous note ROM: the data follows the address by one cycle.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Count the player-visible pulses so sequences can check totals.
  always @(posedge clk) begin
    if (new_note)  nn_count <= nn_count + 1;
    if (song_done) sd_count <= sd_count + 1;
  end

  typedef struct {
    logic       play;
    logic [1:0] song;
    logic       nd;
    logic       exp_nn;
    logic       exp_sd;
    logic [6:0] exp_addr;
    logic [5:0] exp_note;
    logic [5:0] exp_dur;
  } vec_t;

  vec_t vecs [14];

  // Drive the inputs, then advance one clock and settle just after the edge.
  task automatic applyStimulus(input logic p, input logic [1:0] s, input logic nd);
    play      = p;
    song      = s;
    note_done = nd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Step with the current play/song until new_note appears; the caller's trigger step counts as 1.
  task automatic wait_new_note(output int lat);
    lat = 1;
    while (!new_note && lat < 8) begin
      applyStimulus(play, song, 1'b0);
      lat++;
    end
  endtask

  task automatic reset_dut();
    reset     = 1'b0;
    play      = 1'b0;
    song      = 2'd0;
    note_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int lat;
    int nn_start;
    int sd_start;

    for (int i = 0; i < 128; i++) rom[i] = {6'(i), 6'd1};
    for (int i = 0; i < 32; i++) rom[i] = {6'(12 + i), 6'(8 + i)};
    rom[32] = {6'd5, 6'd3};
    rom[33] = {6'd7, 6'd4};
    rom[34] = {6'd0, 6'd0};
    for (int i = 0; i < 32; i++) rom[64 + i] = {6'(20 + i), 6'(1 + i)};

    vecs[0]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 7'd32, 6'd0, 6'd0};
    vecs[1]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 7'd32, 6'd0, 6'd0};
    vecs[2]  = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 7'd32, 6'd5, 6'd3};
    vecs[3]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 7'd32, 6'd5, 6'd3};
    vecs[4]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 7'd32, 6'd5, 6'd3};
    vecs[5]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 7'd33, 6'd5, 6'd3};
    vecs[6]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 7'd33, 6'd5, 6'd3};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 7'd33, 6'd7, 6'd4};
    vecs[8]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 7'd33, 6'd7, 6'd4};
    vecs[9]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 7'd34, 6'd7, 6'd4};
    vecs[10] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 7'd34, 6'd7, 6'd4};
    vecs[11] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 7'd34, 6'd0, 6'd0};
    vecs[12] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 7'd32, 6'd0, 6'd0};
    vecs[13] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 7'd32, 6'd0, 6'd0};

    // Reset state.
    reset_dut();
    reset = 1'b0;
    #1;
    checkOutput("rst_rom_addr", int'(rom_addr), 0);
    checkOutput("rst_note", int'(note), 0);
    checkOutput("rst_duration", int'(duration), 0);
    checkOutput("rst_new_note", int'(new_note), 0);
    checkOutput("rst_song_done", int'(song_done), 0);
    reset_dut();

    // Song 1 with an end marker, cycle by cycle.
    nn_start = nn_count;
    sd_start = sd_count;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].play, vecs[i].song, vecs[i].nd);
      checkOutput($sformatf("vec%0d_new_note", i), int'(new_note), int'(vecs[i].exp_nn));
      checkOutput($sformatf("vec%0d_song_done", i), int'(song_done), int'(vecs[i].exp_sd));
      checkOutput($sformatf("vec%0d_rom_addr", i), int'(rom_addr), int'(vecs[i].exp_addr));
      checkOutput($sformatf("vec%0d_note", i), int'(note), int'(vecs[i].exp_note));
      checkOutput($sformatf("vec%0d_duration", i), int'(duration), int'(vecs[i].exp_dur));
    end
    checkOutput("song1_new_note_count", nn_count - nn_start, 2);
    checkOutput("song1_song_done_count", sd_count - sd_start, 1);

    // Full 32-note song 0, then the automatic restart while play stays high.
    reset_dut();
    nn_start = nn_count;
    applyStimulus(1'b1, 2'd0, 1'b0);
    for (int n = 0; n < 32; n++) begin
      wait_new_note(lat);
      checkOutput($sformatf("full%0d_latency", n), lat, 3);
      checkOutput($sformatf("full%0d_note", n), int'(note), 12 + n);
      checkOutput($sformatf("full%0d_duration", n), int'(duration), 8 + n);
      checkOutput($sformatf("full%0d_addr", n), int'(rom_addr), n);
      applyStimulus(1'b1, 2'd0, 1'b0);
      applyStimulus(1'b1, 2'd0, 1'b1);
    end
    checkOutput("full_song_done", int'(song_done), 1);
    checkOutput("full_no_new_note_at_end", int'(new_note), 0);
    checkOutput("full_new_note_count", nn_count - nn_start, 32);
    applyStimulus(1'b1, 2'd0, 1'b0);
    checkOutput("full_song_done_one_cycle", int'(song_done), 0);
    checkOutput("full_addr_back_to_0", int'(rom_addr), 0);
    applyStimulus(1'b1, 2'd0, 1'b0);
    wait_new_note(lat);
    checkOutput("restart_latency", lat, 3);
    checkOutput("restart_note", int'(note), 12);

    // Advance to note 3, then pause together with note_done.
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 2'd0, 1'b0);
      applyStimulus(1'b1, 2'd0, 1'b1);
      wait_new_note(lat);
    end
    checkOutput("pre_pause_addr", int'(rom_addr), 3);
    applyStimulus(1'b1, 2'd0, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b1);
    checkOutput("pause_keeps_addr", int'(rom_addr), 3);
    checkOutput("pause_no_song_done", int'(song_done), 0);
    applyStimulus(1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 2'd0, 1'b0);
    wait_new_note(lat);
    checkOutput("resume_latency", lat, 3);
    checkOutput("resume_note", int'(note), 15);
    checkOutput("resume_addr", int'(rom_addr), 3);

    // Song select changes while playing take effect only on leaving IDLE.
    applyStimulus(1'b1, 2'd2, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0);
    checkOutput("song_change_ignored_while_playing", int'(rom_addr), 3);
    applyStimulus(1'b0, 2'd2, 1'b0);
    checkOutput("song_change_idle_addr", int'(rom_addr), 3);
    applyStimulus(1'b1, 2'd2, 1'b0);
    checkOutput("song_change_fetch_addr", int'(rom_addr), 64);
    wait_new_note(lat);
    checkOutput("song2_note0", int'(note), 20);
    checkOutput("song2_dur0", int'(duration), 1);
    applyStimulus(1'b1, 2'd2, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b1);
    wait_new_note(lat);
    checkOutput("song2_note1_addr", int'(rom_addr), 65);
    applyStimulus(1'b1, 2'd2, 1'b0);
    applyStimulus(1'b0, 2'd2, 1'b0);
    applyStimulus(1'b0, 2'd2, 1'b1);
    checkOutput("stray_idle_addr", int'(rom_addr), 65);
    applyStimulus(1'b1, 2'd2, 1'b0);
    checkOutput("same_song_resume_addr", int'(rom_addr), 65);
    applyStimulus(1'b1, 2'd2, 1'b1);
    applyStimulus(1'b1, 2'd2, 1'b1);
    checkOutput("stray_fetch_latch_new_note", int'(new_note), 1);
    checkOutput("stray_fetch_latch_addr", int'(rom_addr), 65);
    checkOutput("stray_fetch_latch_note", int'(note), 21);

    // Asynchronous reset in the middle of WAIT_DONE.
    applyStimulus(1'b1, 2'd2, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_rom_addr", int'(rom_addr), 0);
    checkOutput("async_rst_note", int'(note), 0);
    checkOutput("async_rst_duration", int'(duration), 0);
    checkOutput("async_rst_new_note", int'(new_note), 0);
    checkOutput("async_rst_song_done", int'(song_done), 0);
    sd_start = sd_count;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("async_rst_no_song_done", sd_count - sd_start, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
